// File: rtl/vm2002_pkg.sv
// Shared types and default sizing for the vending stock arbiter slice.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package vm2002_pkg;

    localparam int NUM_ITEMS_DEF   = 8;
    localparam int COUNT_W_DEF     = 4;
    localparam int COST_W_DEF      = 8;
    localparam int MAX_COUNT_DEF   = 15;
    localparam int ITEM_W          = 3;

    typedef enum logic [ITEM_W-1:0] {
        WATER  = 3'd0,
        SODA   = 3'd1,
        JUICE  = 3'd2,
        CHIPS  = 3'd3,
        CANDY  = 3'd4,
        GUM    = 3'd5,
        BARS   = 3'd6,
        COOKIE = 3'd7      // reserved slot, never stocked
    } item_t;

    typedef enum logic [1:0] {
        NONE         = 2'b00,
        AVAILABLE    = 2'b01,
        OUT_OF_STOCK = 2'b10,
        ERROR        = 2'b11
    } status_t;

    // One-hot state indices and the matching encoding.
    localparam int S_IDLE    = 0;
    localparam int S_EXEC    = 1;
    localparam int S_ACK     = 2;
    localparam int S_RELEASE = 3;

    typedef enum logic [3:0] {
        IDLE    = 4'(1 << S_IDLE),
        EXEC    = 4'(1 << S_EXEC),
        ACK     = 4'(1 << S_ACK),
        RELEASE = 4'(1 << S_RELEASE)
    } arb_state_t;

    typedef enum logic {
        VEND = 1'b0,
        RSTK = 1'b1
    } requester_t;

    function automatic logic item_valid(input logic [ITEM_W-1:0] item);
        return item < ITEM_W'(COOKIE);
    endfunction

endpackage

// File: rtl/vm2002_stock_table.sv
// Per-item stock table: count and cost flops, one async read port, one sync write port.
// Latency: read is combinational; writes land on the next clk edge.
// Backpressure: none; the owner sequences all accesses.
// Ports: rd_addr -> rd_count/rd_cost; wr_addr with independent count/cost write enables.
module vm2002_stock_table
    import vm2002_pkg::*;
#(
    parameter int NUM_ITEMS = NUM_ITEMS_DEF,
    parameter int COUNT_W   = COUNT_W_DEF,
    parameter int COST_W    = COST_W_DEF,
    parameter int AW        = $clog2(NUM_ITEMS)
) (
    input  logic               clk,
    input  logic               hrst_n,
    input  logic [AW-1:0]      rd_addr,
    output logic [COUNT_W-1:0] rd_count,
    output logic [COST_W-1:0]  rd_cost,
    input  logic [AW-1:0]      wr_addr,
    input  logic               wr_count_en,
    input  logic [COUNT_W-1:0] wr_count,
    input  logic               wr_cost_en,
    input  logic [COST_W-1:0]  wr_cost
);

    logic [COUNT_W-1:0] count_q [NUM_ITEMS];
    logic [COST_W-1:0]  cost_q  [NUM_ITEMS];

    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                count_q[i] <= '0;
                cost_q[i]  <= '0;
            end
        end else begin
            if (wr_count_en) count_q[wr_addr] <= wr_count;
            if (wr_cost_en)  cost_q[wr_addr]  <= wr_cost;
        end
    end

    assign rd_count = count_q[rd_addr];
    assign rd_cost  = cost_q[rd_addr];

endmodule

// File: rtl/vm2002_stock_arbiter.sv
// Single owner of the stock table; serialises vend query/commit and restock as one read-modify-write each.
// Latency: req sampled in IDLE at edge N, ack pulses in the cycle after edge N+1; next grant after req falls.
// Backpressure: req/ack handshake, one op in flight; the loser of a tie waits until the winner drops req.
// Ports: vend_* (query/commit, status/cost/count), rstk_* (add units, optional new cost, err), busy.
// Build option VM_RESTOCK_PRIORITY_EN: restock always wins a tie instead of round-robin.
module vm2002_stock_arbiter
    import vm2002_pkg::*;
#(
    parameter int NUM_ITEMS = NUM_ITEMS_DEF,
    parameter int COUNT_W   = COUNT_W_DEF,
    parameter int COST_W    = COST_W_DEF,
    parameter int MAX_COUNT = MAX_COUNT_DEF
) (
    input  logic               clk,
    input  logic               hrst_n,
    input  logic               vend_req,
    input  logic               vend_op,
    input  logic [2:0]         vend_item,
    output logic               vend_ack,
    output logic [1:0]         vend_status,
    output logic [COST_W-1:0]  vend_cost,
    output logic [COUNT_W-1:0] vend_count,
    input  logic               rstk_req,
    input  logic [2:0]         rstk_item,
    input  logic [COUNT_W-1:0] rstk_count,
    input  logic [COST_W-1:0]  rstk_cost,
    output logic               rstk_ack,
    output logic               rstk_err,
    output logic               busy
);

    localparam int AW = $clog2(NUM_ITEMS);
    localparam logic [COUNT_W:0] MAX_SUM = (COUNT_W+1)'(MAX_COUNT);

    arb_state_t         state;
    requester_t         grant_q;
    requester_t         pick;
    logic               op_q;
    logic [2:0]         item_q;
    logic [COUNT_W-1:0] rcount_q;
    logic [COST_W-1:0]  rcost_q;

    logic [COUNT_W-1:0] rd_count;
    logic [COST_W-1:0]  rd_cost;
    logic               wr_count_en;
    logic               wr_cost_en;
    logic [COUNT_W-1:0] wr_count;
    logic [COUNT_W:0]   sum;
    status_t            nx_status;
    logic [COUNT_W-1:0] nx_vcount;
    logic               nx_err;

`ifndef VM_RESTOCK_PRIORITY_EN
    requester_t         last_winner;
`endif

    // Tie-break between simultaneous requests.
    always_comb begin
`ifdef VM_RESTOCK_PRIORITY_EN
        pick = rstk_req ? RSTK : VEND;
`else
        if (vend_req && rstk_req) pick = (last_winner == VEND) ? RSTK : VEND;
        else                      pick = rstk_req ? RSTK : VEND;
`endif
    end

    // Read-modify-write datapath; enables only fire in EXEC so the table
    // changes exactly once per granted operation.
    always_comb begin
        sum         = {1'b0, rd_count} + {1'b0, rcount_q};
        wr_count_en = 1'b0;
        wr_cost_en  = 1'b0;
        wr_count    = rd_count;
        nx_status   = NONE;
        nx_vcount   = rd_count;
        nx_err      = 1'b0;
        if (grant_q == VEND) begin
            if (!item_valid(item_q)) begin
                nx_status = ERROR;
            end else if (rd_count == '0) begin
                nx_status = OUT_OF_STOCK;
            end else begin
                nx_status = AVAILABLE;
                if (op_q) begin
                    nx_vcount   = rd_count - COUNT_W'(1);
                    wr_count    = nx_vcount;
                    wr_count_en = (state == EXEC);
                end
            end
        end else begin
            if (!item_valid(item_q) || sum > MAX_SUM) begin
                nx_err = 1'b1;
            end else begin
                wr_count    = sum[COUNT_W-1:0];
                wr_count_en = (state == EXEC);
                wr_cost_en  = (state == EXEC) && (rcost_q != '0);
            end
        end
    end

    vm2002_stock_table #(
        .NUM_ITEMS (NUM_ITEMS),
        .COUNT_W   (COUNT_W),
        .COST_W    (COST_W),
        .AW        (AW)
    ) u_table (
        .clk         (clk),
        .hrst_n      (hrst_n),
        .rd_addr     (item_q[AW-1:0]),
        .rd_count    (rd_count),
        .rd_cost     (rd_cost),
        .wr_addr     (item_q[AW-1:0]),
        .wr_count_en (wr_count_en),
        .wr_count    (wr_count),
        .wr_cost_en  (wr_cost_en),
        .wr_cost     (rcost_q)
    );

    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            state       <= IDLE;
            grant_q     <= VEND;
            op_q        <= 1'b0;
            item_q      <= '0;
            rcount_q    <= '0;
            rcost_q     <= '0;
            vend_ack    <= 1'b0;
            vend_status <= NONE;
            vend_cost   <= '0;
            vend_count  <= '0;
            rstk_ack    <= 1'b0;
            rstk_err    <= 1'b0;
`ifndef VM_RESTOCK_PRIORITY_EN
            last_winner <= RSTK;
`endif
        end else begin
            vend_ack <= 1'b0;
            rstk_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (vend_req || rstk_req) begin
                        grant_q  <= pick;
                        item_q   <= (pick == VEND) ? vend_item : rstk_item;
                        op_q     <= vend_op;
                        rcount_q <= rstk_count;
                        rcost_q  <= rstk_cost;
`ifndef VM_RESTOCK_PRIORITY_EN
                        last_winner <= pick;
`endif
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (grant_q == VEND) begin
                        vend_ack    <= 1'b1;
                        vend_status <= nx_status;
                        vend_cost   <= rd_cost;
                        vend_count  <= nx_vcount;
                    end else begin
                        rstk_ack    <= 1'b1;
                        rstk_err    <= nx_err;
                    end
                    state <= ACK;
                end
                ACK: state <= RELEASE;
                RELEASE: begin
                    // Hold off the other requester until the winner lets go.
                    if ((grant_q == VEND) ? !vend_req : !rstk_req) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_vm2002_stock_arbiter.sv
// Bench for the stock arbiter: directed vector table, corner sequences, and random ops vs a reference model.
// Latency: checks ack arrives on the second edge after a request is driven in IDLE.
// Backpressure: exercises ties, hold-until-release and early req drop.
module tb_vm2002_stock_arbiter;

    logic       clk = 1'b0;
    logic       hrst_n;
    logic       vend_req, vend_op;
    logic [2:0] vend_item;
    logic       vend_ack;
    logic [1:0] vend_status;
    logic [7:0] vend_cost;
    logic [3:0] vend_count;
    logic       rstk_req;
    logic [2:0] rstk_item;
    logic [3:0] rstk_count;
    logic [7:0] rstk_cost;
    logic       rstk_ack, rstk_err, busy;

    always #5 clk = ~clk;

    vm2002_stock_arbiter dut (
        .clk         (clk),
        .hrst_n      (hrst_n),
        .vend_req    (vend_req),
        .vend_op     (vend_op),
        .vend_item   (vend_item),
        .vend_ack    (vend_ack),
        .vend_status (vend_status),
        .vend_cost   (vend_cost),
        .vend_count  (vend_count),
        .rstk_req    (rstk_req),
        .rstk_item   (rstk_item),
        .rstk_count  (rstk_count),
        .rstk_cost   (rstk_cost),
        .rstk_ack    (rstk_ack),
        .rstk_err    (rstk_err),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain per-item arrays plus who won the last grant.
    int m_cnt  [8];
    int m_cost [8];
    bit m_last_rstk;

    typedef struct {
        bit is_rstk;
        bit op;
        int item;
        int count;
        int cost;
        int exp_a;      // vend status, or rstk_err
        int exp_cost;
        int exp_count;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, bit op, int item, int cnt, int cost, int a, int ecost, int ecnt);
        vec_t v;
        v.is_rstk = r; v.op = op; v.item = item; v.count = cnt; v.cost = cost;
        v.exp_a = a; v.exp_cost = ecost; v.exp_count = ecnt;
        return v;
    endfunction

    task automatic model_reset();
        foreach (m_cnt[i]) begin
            m_cnt[i]  = 0;
            m_cost[i] = 0;
        end
        m_last_rstk = 1'b1;
    endtask

    task automatic model_vend(input bit op, input int item, output int st, output int cs, output int cn);
        if (item == 7) begin
            st = 3;
        end else if (m_cnt[item] == 0) begin
            st = 2;
        end else begin
            st = 1;
            if (op) m_cnt[item] = m_cnt[item] - 1;
        end
        cs = m_cost[item];
        cn = m_cnt[item];
        m_last_rstk = 1'b0;
    endtask

    task automatic model_rstk(input int item, input int cnt, input int cost, output int err);
        if (item == 7 || m_cnt[item] + cnt > 15) begin
            err = 1;
        end else begin
            err = 0;
            m_cnt[item] = m_cnt[item] + cnt;
            if (cost != 0) m_cost[item] = cost;
        end
        m_last_rstk = 1'b1;
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with it idle again.
    task automatic vend_txn(input bit op, input int item, output int st, output int cs, output int cn);
        int k;
        vend_op = op; vend_item = 3'(item); vend_req = 1'b1;
        k = 0;
        while (k < 20) begin
            @(posedge clk); #1; k++;
            if (vend_ack) break;
        end
        check("vend_latency", vend_ack ? k : 99, 2);
        st = vend_status; cs = vend_cost; cn = vend_count;
        vend_req = 1'b0;
        @(posedge clk); #1;
        check("vend_ack_pulse", vend_ack, 0);
        @(posedge clk); #1;
        check("vend_back_idle", busy, 0);
    endtask

    task automatic rstk_txn(input int item, input int cnt, input int cost, output int err);
        int k;
        rstk_item = 3'(item); rstk_count = 4'(cnt); rstk_cost = 8'(cost); rstk_req = 1'b1;
        k = 0;
        while (k < 20) begin
            @(posedge clk); #1; k++;
            if (rstk_ack) break;
        end
        check("rstk_latency", rstk_ack ? k : 99, 2);
        err = rstk_err;
        rstk_req = 1'b0;
        @(posedge clk); #1;
        check("rstk_ack_pulse", rstk_ack, 0);
        @(posedge clk); #1;
        check("rstk_back_idle", busy, 0);
    endtask

    task automatic vend_check(input bit op, input int item);
        int st, cs, cn, est, ecs, ecn;
        vend_txn(op, item, st, cs, cn);
        model_vend(op, item, est, ecs, ecn);
        check("vend_status", st, est);
        check("vend_cost", cs, ecs);
        check("vend_count", cn, ecn);
    endtask

    task automatic rstk_check(input int item, input int cnt, input int cost);
        int err, eerr;
        rstk_txn(item, cnt, cost, err);
        model_rstk(item, cnt, cost, eerr);
        check("rstk_err", err, eerr);
    endtask

    // Both requests raised together; each is dropped as soon as it is acked.
    task automatic tie_txn(input bit vop, input int vitem, input int ritem, input int rcnt, input int rcost);
        bit v_done, r_done;
        int first, first_k, k, exp_first;
        int st, cs, cn, est, ecs, ecn, err, eerr;
        v_done = 0; r_done = 0; first = -1; first_k = 0; k = 0;
`ifdef VM_RESTOCK_PRIORITY_EN
        exp_first = 1;
`else
        exp_first = m_last_rstk ? 0 : 1;
`endif
        vend_op = vop; vend_item = 3'(vitem);
        rstk_item = 3'(ritem); rstk_count = 4'(rcnt); rstk_cost = 8'(rcost);
        vend_req = 1'b1; rstk_req = 1'b1;
        while (!(v_done && r_done) && k < 40) begin
            @(posedge clk); #1; k++;
            if (vend_ack && !v_done) begin
                if (first < 0) begin first = 0; first_k = k; end
                v_done = 1;
                st = vend_status; cs = vend_cost; cn = vend_count;
                vend_req = 1'b0;
                model_vend(vop, vitem, est, ecs, ecn);
                check("tie_vend_status", st, est);
                check("tie_vend_cost", cs, ecs);
                check("tie_vend_count", cn, ecn);
            end
            if (rstk_ack && !r_done) begin
                if (first < 0) begin first = 1; first_k = k; end
                r_done = 1;
                err = rstk_err;
                rstk_req = 1'b0;
                model_rstk(ritem, rcnt, rcost, eerr);
                check("tie_rstk_err", err, eerr);
            end
        end
        vend_req = 1'b0; rstk_req = 1'b0;
        check("tie_order", first, exp_first);
        check("tie_latency", first_k, 2);
        check("tie_complete", int'(v_done && r_done), 1);
        repeat (2) @(posedge clk);
        #1;
        check("tie_back_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, cs, cn, err, k;
        vend_req = 0; vend_op = 0; vend_item = 0;
        rstk_req = 0; rstk_item = 0; rstk_count = 0; rstk_cost = 0;
        hrst_n = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_vend_ack", vend_ack, 0);
        check("rst_rstk_ack", rstk_ack, 0);
        check("rst_vend_status", vend_status, 0);
        check("rst_vend_cost", vend_cost, 0);
        check("rst_vend_count", vend_count, 0);
        check("rst_rstk_err", rstk_err, 0);
        check("rst_busy", busy, 0);
        hrst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors from a fresh table.
        vecs[0]  = mk(0, 0, 0, 0,  0,    2, 8'h00, 0);
        vecs[1]  = mk(1, 0, 1, 5,  8'h19, 0, 0, 0);
        vecs[2]  = mk(0, 1, 1, 0,  0,    1, 8'h19, 4);
        vecs[3]  = mk(1, 0, 2, 12, 8'h33, 0, 0, 0);
        vecs[4]  = mk(1, 0, 2, 4,  8'h44, 1, 0, 0);
        vecs[5]  = mk(0, 0, 2, 0,  0,    1, 8'h33, 12);
        vecs[6]  = mk(1, 0, 3, 1,  0,    0, 0, 0);
        vecs[7]  = mk(0, 1, 3, 0,  0,    1, 8'h00, 0);
        vecs[8]  = mk(0, 1, 3, 0,  0,    2, 8'h00, 0);
        vecs[9]  = mk(0, 0, 7, 0,  0,    3, 8'h00, 0);
        vecs[10] = mk(1, 0, 7, 1,  8'h10, 1, 0, 0);
        vecs[11] = mk(1, 0, 1, 11, 0,    0, 0, 0);
        vecs[12] = mk(0, 0, 1, 0,  0,    1, 8'h19, 15);
        vecs[13] = mk(0, 1, 7, 0,  0,    3, 8'h00, 0);
        vecs[14] = mk(1, 0, 1, 1,  8'h20, 1, 0, 0);
        vecs[15] = mk(0, 0, 1, 0,  0,    1, 8'h19, 15);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_rstk) begin
                rstk_txn(vecs[i].item, vecs[i].count, vecs[i].cost, err);
                check($sformatf("vec%0d_rstk_err", i), err, vecs[i].exp_a);
                model_rstk(vecs[i].item, vecs[i].count, vecs[i].cost, err);
            end else begin
                vend_txn(vecs[i].op, vecs[i].item, st, cs, cn);
                check($sformatf("vec%0d_status", i), st, vecs[i].exp_a);
                check($sformatf("vec%0d_cost", i), cs, vecs[i].exp_cost);
                check($sformatf("vec%0d_count", i), cn, vecs[i].exp_count);
                model_vend(vecs[i].op, vecs[i].item, st, cs, cn);
            end
        end

        // Reset during EXEC of a restock: no ack, table cleared.
        rstk_item = 3'd1; rstk_count = 4'd0; rstk_cost = 8'h55; rstk_req = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy_exec", busy, 1);
        #2 hrst_n = 1'b0;
        #1;
        check("mid_rst_busy_async", busy, 0);
        check("mid_rst_no_ack", rstk_ack, 0);
        check("mid_rst_vend_count", vend_count, 0);
        rstk_req = 1'b0;
        @(posedge clk); @(posedge clk);
        #3 hrst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_ack", int'(rstk_ack | vend_ack), 0);
        end
        vend_check(0, 1);
        vend_check(0, 2);

        // Ties, twice in a row, starting with restock as last winner.
        rstk_check(3, 5, 8'h21);
        tie_txn(1, 3, 4, 2, 8'h07);
        tie_txn(1, 3, 4, 3, 8'h00);

        // Request withdrawn before ack: FSM still completes and idles.
        vend_op = 1'b0; vend_item = 3'd4; vend_req = 1'b1;
        @(posedge clk); #1;
        vend_req = 1'b0;
        k = 0;
        while (k < 10) begin
            @(posedge clk); #1; k++;
            if (!busy) break;
        end
        check("early_drop_idle", busy ? 99 : k, 3);
        m_last_rstk = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            int sel, ritem, rcnt, rcost;
            sel   = $urandom_range(0, 3);
            ritem = $urandom_range(0, 7);
            rcnt  = $urandom_range(0, 9);
            rcost = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 255);
            if (sel == 0)
                tie_txn(1'($urandom_range(0, 1)), $urandom_range(0, 7), ritem, rcnt, rcost);
            else if (sel == 1)
                rstk_check(ritem, rcnt, rcost);
            else
                vend_check(1'($urandom_range(0, 1)), $urandom_range(0, 7));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vm2002_stock_arbiter.md
Name: vm2002_stock_arbiter

Overview:
Owns the shared per-item stock table: an 8-bit cost and a count per item. Serialises access to it between two requesters: the customer-side vend FSM (query/commit) and the supplier restock interface. One operation runs at a time, with round-robin arbitration and a req/ack handshake. It replaces the ad-hoc item_count/cost updates scattered through the vend FSM with a single sequenced read-modify-write owner.

Parameters:
NUM_ITEMS, 8, table depth; indices 0..6 are valid (WATER..BARS), index 7 (COOKIE) is reserved.
COUNT_W, 4, width of each stock count.
COST_W, 8, width of each cost entry.
MAX_COUNT, 15, highest legal stock count after a restock.

Ports:
clk  in  1  single clock, rising edge.
hrst_n  in  1  reset, asynchronous, active-low.
vend_req  in  1  vend request; held high with fields stable until vend_ack.
vend_op  in  1  0 = query (no table change), 1 = commit (take one unit).
vend_item  in  3  item index.
vend_ack  out  1  one-cycle pulse; vend response fields valid in this cycle.
vend_status  out  2  response status, using status_t.
vend_cost  out  COST_W  cost entry of vend_item.
vend_count  out  COUNT_W  count after the operation.
rstk_req  in  1  restock request; held high with fields stable until rstk_ack.
rstk_item  in  3  item index.
rstk_count  in  COUNT_W  units to add.
rstk_cost  in  COST_W  new cost; 0 = keep the existing cost.
rstk_ack  out  1  one-cycle pulse.
rstk_err  out  1  valid with rstk_ack; 1 = rejected, table unchanged.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (hrst_n low, async): state IDLE; all acks, status, cost, count, rstk_err and busy = 0; table counts and costs = 0; last_winner = RSTK, so vend wins the first tie.
- Reset mid-operation: the operation is dropped with no ack, and any table write not yet clocked is lost.
- FSM states: IDLE -> EXEC -> ACK -> RELEASE -> IDLE.
- IDLE:
  - One request high: grant it.
  - Both high: grant the requester that is not last_winner.
  - On grant, latch the op, item and operands, update last_winner, and go to EXEC.
- EXEC (one cycle): read the entry, compute, write the table on the clock edge, register the responses, go to ACK.
- ACK: the granted requester's ack = 1 for exactly one cycle, with its response fields. Go to RELEASE.
- RELEASE: wait until the granted requester's req = 0, then go to IDLE. The other requester is never granted while in RELEASE.
- Latency: req seen high in IDLE at edge N; ack high in cycle N+2; the earliest next grant is at the edge after req falls.
- Invalid item (7), any op: vend_status = ERROR, or rstk_err = 1; the table is unchanged.
- Vend query: status = AVAILABLE if count != 0, else OUT_OF_STOCK. vend_cost and vend_count are returned unchanged.
- Vend commit:
  - count == 0: OUT_OF_STOCK, no change.
  - Otherwise: count - 1 is written and returned, status = AVAILABLE.
  - The count never wraps below 0.
- Restock:
  - The sum is computed at COUNT_W+1 bits.
  - sum > MAX_COUNT: rstk_err = 1; neither the count nor the cost is written.
  - Otherwise: the count is written with the sum; the cost is written only if rstk_cost != 0.
- Response fields hold their values after ack until the next ack. Only the ack signals are pulses.
- A req that drops before its ack (protocol violation) has no required behaviour, but the FSM must still complete the operation and return to IDLE.

Optional Feature:
VM_RESTOCK_PRIORITY_EN
- Defined: fixed priority; rstk_req always wins a tie in IDLE, and last_winner is unused.
- Undefined: round-robin as above.

Decomposition:
- The package vm2002_pkg holds:
  - item_t enum (WATER=0 .. BARS=6, COOKIE=7 reserved).
  - status_t: NONE=2'b00, AVAILABLE=2'b01, OUT_OF_STOCK=2'b10, ERROR=2'b11.
  - arb_state_t with one-hot indices.
  - requester_t {VEND, RSTK}.
  - Default widths and the MAX_COUNT constant.
- Sub-module vm2002_stock_table: NUM_ITEMS x (COUNT_W + COST_W) flop array with one combinational read port and one synchronous write port with per-field write enables. It is cleared by hrst_n.

Test Plan:
- After reset, vend query on item 0 -> ack in cycle N+2; status OUT_OF_STOCK, cost 0, count 0.
- Restock item 1: count 5, cost 0x19 -> rstk_err 0. Then vend commit item 1 -> AVAILABLE, count 4, cost 0x19.
- Item 2 at count 12, restock count 4 (sum 16) -> rstk_err 1; count stays 12 and the cost is unchanged.
- vend_req and rstk_req rise on the same edge, twice in a row -> vend is served first, then restock.
  - With VM_RESTOCK_PRIORITY_EN defined: restock is served first both times.
- Commit item 3 with count 1, twice -> AVAILABLE with count 0, then OUT_OF_STOCK with count 0 (no wrap). Item 7 -> ERROR.
- Assert hrst_n low during EXEC of a restock -> no ack; busy 0 asynchronously; a later query shows count 0 and cost 0.
